// File: rtl/mem_pkg.sv
// Shared sizing for the packet memory: block index width and block word width.
package mem_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned BLOCK_BITS = 64;

endpackage

// File: rtl/memory_read_ctrl_if.sv
// Handshake bundle between the frame read controller and its neighbours.
//   start_*    : frame descriptor queue (valid/ready)
//   mem_*      : memory read request / grant / read data
//   fl_free_*  : block return to the free list (req/gnt)
//   data_*     : byte stream to the tx MAC (valid/ready, sof/eof)
// slave  : controller side, master : environment side.
interface memory_read_ctrl_if #(
    parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
    parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS
);

    logic [ADDR_W-1:0]     start_addr_i;
    logic                  start_valid_i;
    logic                  start_ready_o;

    logic                  mem_re_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic                  mem_gnt_i;
    logic [BLOCK_BITS-1:0] mem_rdata_i;

    logic                  fl_free_req_o;
    logic [ADDR_W-1:0]     fl_free_block_idx_o;
    logic                  fl_free_gnt_i;

    logic [7:0]            data_o;
    logic                  data_valid_o;
    logic                  data_ready_i;
    logic                  data_sof_o;
    logic                  data_eof_o;

    modport slave (
        input  start_addr_i, start_valid_i, mem_gnt_i, mem_rdata_i,
               fl_free_gnt_i, data_ready_i,
        output start_ready_o, mem_re_o, mem_addr_o, fl_free_req_o,
               fl_free_block_idx_o, data_o, data_valid_o, data_sof_o, data_eof_o
    );

    modport master (
        output start_addr_i, start_valid_i, mem_gnt_i, mem_rdata_i,
               fl_free_gnt_i, data_ready_i,
        input  start_ready_o, mem_re_o, mem_addr_o, fl_free_req_o,
               fl_free_block_idx_o, data_o, data_valid_o, data_sof_o, data_eof_o
    );

endinterface

// File: rtl/memory_read_ctrl.sv
// Frame read controller: walks a linked list of memory blocks starting at a
// queued block index, streams each block's payload bytes to the tx MAC and
// returns every block to the free list once its last byte has been taken.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : memory_read_ctrl_if.slave (descriptor, memory read, free list,
//          byte stream handshakes)
// Block word: [ADDR_W-1:0] next index, [ADDR_W] last flag,
//             [ADDR_W+1 +: CNT_W] byte count, payload byte k at [HDR_W+8k +: 8].
module memory_read_ctrl #(
    parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
    parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    memory_read_ctrl_if.slave bus
);

    localparam int unsigned HDR_W         = ADDR_W + 1 + CNT_W;
    localparam int unsigned PAYLOAD_BYTES = (BLOCK_BITS - HDR_W) / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_STREAM,
        S_FREE
    } state_t;

    // Byte count with N=0 promoted to one byte and oversize counts clamped.
    function automatic logic [CNT_W-1:0] eff_count(input logic [BLOCK_BITS-1:0] word);
        logic [CNT_W-1:0] n;
        n = word[ADDR_W+1 +: CNT_W];
        if (n == '0)
            eff_count = CNT_W'(1);
        else if (n > CNT_W'(PAYLOAD_BYTES))
            eff_count = CNT_W'(PAYLOAD_BYTES);
        else
            eff_count = n;
    endfunction

    function automatic logic [7:0] payload_byte(input logic [BLOCK_BITS-1:0] word,
                                                input logic [CNT_W-1:0]      idx);
        logic [BLOCK_BITS-1:0] sh;
        sh = word >> (HDR_W + 8 * int'(idx));
        payload_byte = sh[7:0];
    endfunction

    state_t                r_state;
    logic [ADDR_W-1:0]     r_cur_idx;
    logic [BLOCK_BITS-1:0] r_block;
    logic [CNT_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_last_ptr;
    logic                  r_first;

    logic                  r_start_ready;
    logic                  r_mem_re;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_fl_req;
    logic [ADDR_W-1:0]     r_fl_idx;
    logic [7:0]            r_data;
    logic                  r_data_valid;
    logic                  r_sof;
    logic                  r_eof;

    logic [ADDR_W-1:0]     w_blk_next;
    logic                  w_blk_last;
    logic [CNT_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]      w_rd_cnt;
    logic                  w_rd_last;

    assign w_blk_next = r_block[ADDR_W-1:0];
    assign w_blk_last = r_block[ADDR_W];
    assign w_ptr_nxt  = r_ptr + CNT_W'(1);
    assign w_rd_cnt   = eff_count(bus.mem_rdata_i);
    assign w_rd_last  = bus.mem_rdata_i[ADDR_W];

    // Control FSM; every output is a register updated on the transition into
    // the state that owns it, so outputs line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_idx     <= '0;
            r_block       <= '0;
            r_ptr         <= '0;
            r_last_ptr    <= '0;
            r_first       <= 1'b0;
            r_start_ready <= 1'b0;
            r_mem_re      <= 1'b0;
            r_mem_addr    <= '0;
            r_fl_req      <= 1'b0;
            r_fl_idx      <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_sof         <= 1'b0;
            r_eof         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start_ready && bus.start_valid_i) begin
                        r_start_ready <= 1'b0;
                        r_cur_idx     <= bus.start_addr_i;
                        r_mem_re      <= 1'b1;
                        r_mem_addr    <= bus.start_addr_i;
                        r_first       <= 1'b1;
                        r_state       <= S_RD_REQ;
                    end else begin
                        r_start_ready <= 1'b1;
                    end
                end

                S_RD_REQ: begin
                    if (bus.mem_gnt_i) begin
                        r_mem_re <= 1'b0;
                        r_state  <= S_RD_WAIT;
                    end
                end

                // Read data arrives the cycle after the grant; byte 0 is
                // presented straight from it so streaming starts next cycle.
                S_RD_WAIT: begin
                    r_block      <= bus.mem_rdata_i;
                    r_ptr        <= '0;
                    r_last_ptr   <= w_rd_cnt - CNT_W'(1);
                    r_data       <= payload_byte(bus.mem_rdata_i, CNT_W'(0));
                    r_data_valid <= 1'b1;
                    r_sof        <= r_first;
                    r_eof        <= w_rd_last && (w_rd_cnt == CNT_W'(1));
                    r_first      <= 1'b0;
                    r_state      <= S_STREAM;
                end

                S_STREAM: begin
                    if (r_data_valid && bus.data_ready_i) begin
                        if (r_ptr == r_last_ptr) begin
                            r_data_valid <= 1'b0;
                            r_sof        <= 1'b0;
                            r_eof        <= 1'b0;
                            r_fl_req     <= 1'b1;
                            r_fl_idx     <= r_cur_idx;
                            r_state      <= S_FREE;
                        end else begin
                            r_ptr  <= w_ptr_nxt;
                            r_data <= payload_byte(r_block, w_ptr_nxt);
                            r_sof  <= 1'b0;
                            r_eof  <= w_blk_last && (w_ptr_nxt == r_last_ptr);
                        end
                    end
                end

                S_FREE: begin
                    if (bus.fl_free_gnt_i) begin
                        r_fl_req <= 1'b0;
                        if (w_blk_last) begin
                            r_start_ready <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_cur_idx  <= w_blk_next;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= w_blk_next;
                            r_state    <= S_RD_REQ;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready_o       = r_start_ready;
    assign bus.mem_re_o            = r_mem_re;
    assign bus.mem_addr_o          = r_mem_addr;
    assign bus.fl_free_req_o       = r_fl_req;
    assign bus.fl_free_block_idx_o = r_fl_idx;
    assign bus.data_o              = r_data;
    assign bus.data_valid_o        = r_data_valid;
    assign bus.data_sof_o          = r_sof;
    assign bus.data_eof_o          = r_eof;

endmodule
